// File: rtl/ste_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// One-deep pending buffer keeps the newest sample that arrives mid-conversion.
module ste_bin2bcd #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            din_i,
  input  logic                         din_update_i,
  input  logic                         clr_i,
  output logic [4*DIGITS-1:0]          bcd_o,
  output logic [$clog2(DIGITS+1)-1:0]  nz_digits_o,
  output logic                         overflow_o,
  output logic                         bcd_valid_o,
  output logic                         busy_o
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int NZ_W  = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [DATA_W-1:0] bin_q;
  logic [SCR_W-1:0]  scr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sov_q;
  logic [DATA_W-1:0] pend_q;
  logic              pend_v_q;

  logic              last;
  logic              load_new;
  logic              load_pend;
  logic              do_shift;
  logic              do_done;
  logic              pend_wr;
  logic              pend_clr;

  logic [SCR_W-1:0]  scr_adj;
  logic [SCR_W-1:0]  res;
  logic [NZ_W-1:0]   nz_nx;
  logic [DATA_W-1:0] src;

  assign last   = (cnt_q == CNT_W'(DATA_W - 1));
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (din_update_i) begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (din_update_i || pend_v_q) begin
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load_new  = 1'b0;
    load_pend = 1'b0;
    do_shift  = 1'b0;
    do_done   = 1'b0;
    pend_wr   = 1'b0;
    pend_clr  = 1'b0;
    if (clr_i) begin
      pend_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          load_new = din_update_i;
        end
        SHIFT: begin
          do_shift = 1'b1;
          pend_wr  = din_update_i;
        end
        DONE: begin
          do_done = 1'b1;
          if (din_update_i) begin
            load_new = 1'b1;
            pend_clr = 1'b1;
          end else if (pend_v_q) begin
            load_pend = 1'b1;
            pend_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-nibble add-3; no carry crosses a digit boundary.
  always_comb begin
    scr_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) begin
        scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end else begin
        scr_adj[4*k +: 4] = scr_q[4*k +: 4];
      end
    end
  end

  assign res = sov_q ? {DIGITS{4'h9}} : scr_q;
  assign src = load_pend ? pend_q : din_i;

  always_comb begin
    nz_nx = NZ_W'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (res[4*k +: 4] != 4'd0) begin
        nz_nx = NZ_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      sov_q <= 1'b0;
    end else if (load_new || load_pend) begin
      bin_q <= src;
      scr_q <= '0;
      cnt_q <= '0;
      sov_q <= 1'b0;
    end else if (do_shift) begin
      {scr_q, bin_q} <= {scr_adj[SCR_W-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q + CNT_W'(1);
      if (scr_adj[SCR_W-1]) begin
        sov_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else if (pend_clr) begin
      pend_v_q <= 1'b0;
    end else if (pend_wr) begin
      pend_q   <= din_i;
      pend_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_o       <= '0;
      nz_digits_o <= NZ_W'(1);
      overflow_o  <= 1'b0;
      bcd_valid_o <= 1'b0;
    end else if (clr_i) begin
      bcd_o       <= '0;
      nz_digits_o <= NZ_W'(1);
      overflow_o  <= 1'b0;
      bcd_valid_o <= 1'b0;
    end else if (do_done) begin
      bcd_o       <= res;
      nz_digits_o <= nz_nx;
      overflow_o  <= sov_q;
      bcd_valid_o <= 1'b1;
    end else begin
      bcd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ste_bin2bcd.sv
// Bench for ste_bin2bcd: transaction-level model plus directed vectors.
// Two instances cover DIGITS=5 (default) and DIGITS=4 (overflow).
module tb_ste_bin2bcd;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [DW-1:0] din0 = '0;
  logic [DW-1:0] din1 = '0;
  logic upd0 = 1'b0;
  logic upd1 = 1'b0;

  logic [19:0] bcd0;
  logic [2:0]  nz0;
  logic        ov0, v0, b0;
  logic [15:0] bcd1;
  logic [2:0]  nz1;
  logic        ov1, v1, b1;

  int errs = 0;
  int checks = 0;
  int bcnt = 0;

  always #5 clk = ~clk;

  ste_bin2bcd u0 (
    .clk(clk), .rst_n(rst_n), .din_i(din0), .din_update_i(upd0),
    .clr_i(clr), .bcd_o(bcd0), .nz_digits_o(nz0), .overflow_o(ov0),
    .bcd_valid_o(v0), .busy_o(b0)
  );

  ste_bin2bcd #(.DATA_W(DW), .DIGITS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .din_i(din1), .din_update_i(upd1),
    .clr_i(clr), .bcd_o(bcd1), .nz_digits_o(nz1), .overflow_o(ov1),
    .bcd_valid_o(v1), .busy_o(b1)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Expected conversion result from plain decimal arithmetic.
  function automatic void conv(input int v, input int d,
                               output logic [39:0] b, output int nz,
                               output bit ov);
    longint lim;
    int t;
    lim = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    b = '0;
    ov = (longint'(v) >= lim);
    if (ov) begin
      for (int k = 0; k < d; k++) b[4*k +: 4] = 4'h9;
      nz = d;
    end else begin
      t = v;
      for (int k = 0; k < d; k++) begin
        b[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
      nz = 1;
      t = v / 10;
      while (t > 0) begin
        nz++;
        t = t / 10;
      end
    end
  endfunction

  bit          act[2];
  int          rem[2];
  int          val[2];
  bit          pv[2];
  int          pend[2];
  logic [39:0] e_bcd[2];
  int          e_nz[2];
  bit          e_ov[2];
  bit          e_v[2];

  // A result appears DW+1 edges after a conversion starts.
  task automatic mstep(input int i, input bit u, input int d);
    e_v[i] = 1'b0;
    if (clr) begin
      act[i] = 1'b0;
      pv[i] = 1'b0;
      e_bcd[i] = '0;
      e_nz[i] = 1;
      e_ov[i] = 1'b0;
    end else if (act[i]) begin
      rem[i]--;
      if (rem[i] == 0) begin
        conv(val[i], (i == 0) ? 5 : 4, e_bcd[i], e_nz[i], e_ov[i]);
        e_v[i] = 1'b1;
        if (u) begin
          val[i] = d;
          rem[i] = DW + 1;
          pv[i] = 1'b0;
        end else if (pv[i]) begin
          val[i] = pend[i];
          rem[i] = DW + 1;
          pv[i] = 1'b0;
        end else begin
          act[i] = 1'b0;
        end
      end else if (u) begin
        pend[i] = d;
        pv[i] = 1'b1;
      end
    end else if (u) begin
      act[i] = 1'b1;
      val[i] = d;
      rem[i] = DW + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0;
        pv[i] = 1'b0;
        rem[i] = 0;
        e_bcd[i] = '0;
        e_nz[i] = 1;
        e_ov[i] = 1'b0;
        e_v[i] = 1'b0;
      end
    end else begin
      mstep(0, upd0, int'(din0));
      mstep(1, upd1, int'(din1));
    end
  end

  always @(negedge clk) begin
    chk("cyc_bcd0", 64'(bcd0), 64'(e_bcd[0][19:0]));
    chk("cyc_nz0", 64'(nz0), 64'(e_nz[0]));
    chk("cyc_ov0", 64'(ov0), 64'(e_ov[0]));
    chk("cyc_v0", 64'(v0), 64'(e_v[0]));
    chk("cyc_busy0", 64'(b0), 64'(act[0]));
    chk("cyc_bcd1", 64'(bcd1), 64'(e_bcd[1][15:0]));
    chk("cyc_nz1", 64'(nz1), 64'(e_nz[1]));
    chk("cyc_ov1", 64'(ov1), 64'(e_ov[1]));
    chk("cyc_v1", 64'(v1), 64'(e_v[1]));
    chk("cyc_busy1", 64'(b1), 64'(act[1]));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe(input int i, input int v);
    if (i == 0) begin
      din0 = DW'(v);
      upd0 = 1'b1;
    end else begin
      din1 = DW'(v);
      upd1 = 1'b1;
    end
    @(posedge clk);
    #1;
    bcnt = (i == 0) ? int'(b0) : int'(b1);
    #1;
    upd0 = 1'b0;
    upd1 = 1'b0;
  endtask

  task automatic wait_v(input int i, input int lim, output int n);
    n = -1;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk);
      #1;
      bcnt += (i == 0) ? int'(b0) : int'(b1);
      if (((i == 0) ? v0 : v1) === 1'b1) begin
        n = c;
        break;
      end
    end
    #1;
  endtask

  int n;

  initial begin
    #12;
    chk("rst_bcd", 64'(bcd0), 64'h0);
    chk("rst_nz", 64'(nz0), 64'd1);
    chk("rst_ov", 64'(ov0), 64'd0);
    chk("rst_v", 64'(v0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(2);

    strobe(0, 0);
    wait_v(0, 40, n);
    chk("lat_zero", 64'(n), 64'd17);
    chk("zero_bcd", 64'(bcd0), 64'h0);
    chk("zero_nz", 64'(nz0), 64'd1);
    chk("zero_ov", 64'(ov0), 64'd0);
    tick(2);

    strobe(0, 65535);
    wait_v(0, 40, n);
    chk("max_lat", 64'(n), 64'd17);
    chk("max_bcd", 64'(bcd0), 64'h65535);
    chk("max_nz", 64'(nz0), 64'd5);
    chk("max_ov", 64'(ov0), 64'd0);
    chk("max_busy_cycles", 64'(bcnt), 64'd17);
    tick(2);

    strobe(0, 1234);
    tick(3);
    strobe(0, 777);
    tick(2);
    strobe(0, 42);
    wait_v(0, 40, n);
    chk("p1_bcd", 64'(bcd0), 64'h01234);
    chk("p1_nz", 64'(nz0), 64'd4);
    wait_v(0, 40, n);
    chk("p2_lat", 64'(n), 64'd17);
    chk("p2_bcd", 64'(bcd0), 64'h00042);
    chk("p2_nz", 64'(nz0), 64'd2);
    wait_v(0, 40, n);
    chk("no_third_pulse", 64'(n < 0), 64'd1);

    strobe(1, 12345);
    wait_v(1, 40, n);
    chk("d4_lat", 64'(n), 64'd17);
    chk("d4_bcd", 64'(bcd1), 64'h9999);
    chk("d4_ov", 64'(ov1), 64'd1);
    chk("d4_nz", 64'(nz1), 64'd4);
    tick(1);
    strobe(1, 5);
    wait_v(1, 40, n);
    chk("d4b_bcd", 64'(bcd1), 64'h0005);
    chk("d4b_ov", 64'(ov1), 64'd0);
    chk("d4b_nz", 64'(nz1), 64'd1);
    tick(1);

    strobe(0, 500);
    tick(7);
    clr = 1'b1;
    upd0 = 1'b1;
    din0 = DW'(321);
    @(posedge clk);
    #1;
    chk("clr_busy", 64'(b0), 64'd0);
    chk("clr_bcd", 64'(bcd0), 64'h0);
    chk("clr_nz", 64'(nz0), 64'd1);
    chk("clr_v", 64'(v0), 64'd0);
    #1;
    clr = 1'b0;
    upd0 = 1'b0;
    wait_v(0, 40, n);
    chk("clr_no_pulse", 64'(n < 0), 64'd1);

    strobe(0, 31);
    wait_v(0, 40, n);
    chk("r31_bcd", 64'(bcd0), 64'h00031);
    chk("r31_nz", 64'(nz0), 64'd2);
    tick(1);
    strobe(0, 12345);
    tick(5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_bcd", 64'(bcd0), 64'h0);
    chk("arst_nz", 64'(nz0), 64'd1);
    chk("arst_v", 64'(v0), 64'd0);
    chk("arst_busy", 64'(b0), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_v(0, 40, n);
    chk("arst_no_pulse", 64'(n < 0), 64'd1);
    strobe(0, 9);
    wait_v(0, 40, n);
    chk("nine_lat", 64'(n), 64'd17);
    chk("nine_bcd", 64'(bcd0), 64'h00009);
    chk("nine_nz", 64'(nz0), 64'd1);
    chk("nine_ov", 64'(ov0), 64'd0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
